// File: rtl/alu_status_unit_if.sv
// rtl/alu_status_unit_if.sv - request and writeback signals between CPU control and the status ALU
interface alu_status_unit_if #(
    parameter int DW = 8
);
    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [7:0]    status_in;
    logic [2:0]    dest;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [7:0]    status_out;
    logic          accumulator_con;
    logic          x_con;
    logic          y_con;
    logic          stack_pointer_con;
    logic          status_con;

    modport master (
        output start, op, a, b, status_in, dest,
        input  busy, done, result, status_out,
               accumulator_con, x_con, y_con, stack_pointer_con, status_con
    );

    modport slave (
        input  start, op, a, b, status_in, dest,
        output busy, done, result, status_out,
               accumulator_con, x_con, y_con, stack_pointer_con, status_con
    );
endinterface

// File: rtl/alu_status_unit.sv
// rtl/alu_status_unit.sv - multi-cycle 6502-style ALU with NV-BDIZC flags and register write strobes
module alu_status_unit #(
    parameter int DW        = 8,
    parameter bit SUPPORT_D = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_status_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

    localparam logic [3:0] OP_ADC  = 4'd0;
    localparam logic [3:0] OP_SBC  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORA  = 4'd3;
    localparam logic [3:0] OP_EOR  = 4'd4;
    localparam logic [3:0] OP_ASL  = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_DEC  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_BIT  = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd14;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [7:0]    p_q, p_d;
    logic [2:0]    dest_q, dest_d;
    logic          done_q, done_d;
    logic [DW-1:0] result_q, result_d;
    logic [7:0]    status_q, status_d;
    logic [4:0]    stb_q, stb_d;

    logic          c_in, is_dec, writes_reg;
    logic [DW-1:0] b_eff, bin_r, flag_val;
    logic [DW:0]   sum9, diff9;
    logic          bin_n, bin_v, bin_z, bin_c;
    logic [5:0]    lo_add, lo_add_adj, hi_add, hi_add_adj;
    logic [4:0]    lo_sub, hi_sub;
    logic [3:0]    lo_sub_adj, hi_sub_adj;
    logic [7:0]    dec_r;
    logic          dec_c;

    assign c_in       = p_q[0];
    assign is_dec     = SUPPORT_D && p_q[3] && (op_q == OP_ADC || op_q == OP_SBC);
    assign writes_reg = (op_q <= OP_DEC) || (op_q == OP_PASS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    state_d = is_dec ? ADJ : DONE;
            ADJ:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        dest_d = dest_q;
        if (state_q == IDLE && bus.start) begin
            op_d   = bus.op;
            a_d    = bus.a;
            b_d    = bus.b;
            p_d    = bus.status_in;
            dest_d = bus.dest;
        end
    end

    // Binary datapath; CMP flags come from a-b while the result stays a.
    always_comb begin
        b_eff = (op_q == OP_SBC) ? ~b_q : b_q;
        sum9  = {1'b0, a_q} + {1'b0, b_eff} + {{DW{1'b0}}, c_in};
        diff9 = {1'b0, a_q} + {1'b0, ~b_q} + {{DW{1'b0}}, 1'b1};
        bin_r = a_q;
        bin_c = c_in;
        bin_v = p_q[6];
        case (op_q)
            OP_ADC, OP_SBC: begin
                bin_r = sum9[DW-1:0];
                bin_c = sum9[DW];
                bin_v = (a_q[DW-1] == b_eff[DW-1]) && (sum9[DW-1] != a_q[DW-1]);
            end
            OP_AND:  bin_r = a_q & b_q;
            OP_ORA:  bin_r = a_q | b_q;
            OP_EOR:  bin_r = a_q ^ b_q;
            OP_ASL:  begin bin_r = {a_q[DW-2:0], 1'b0}; bin_c = a_q[DW-1]; end
            OP_LSR:  begin bin_r = {1'b0, a_q[DW-1:1]}; bin_c = a_q[0];    end
            OP_ROL:  begin bin_r = {a_q[DW-2:0], c_in}; bin_c = a_q[DW-1]; end
            OP_ROR:  begin bin_r = {c_in, a_q[DW-1:1]}; bin_c = a_q[0];    end
            OP_INC:  bin_r = a_q + 1'b1;
            OP_DEC:  bin_r = a_q - 1'b1;
            OP_CMP:  bin_c = diff9[DW];
            OP_BIT:  bin_v = b_q[6];
            OP_PASS: bin_r = b_q;
            default: bin_r = a_q;
        endcase
        flag_val = (op_q == OP_CMP) ? diff9[DW-1:0] : bin_r;
        bin_n    = (op_q == OP_BIT) ? b_q[DW-1] : flag_val[DW-1];
        bin_z    = (op_q == OP_BIT) ? ((a_q & b_q) == '0) : (flag_val == '0);
    end

    // BCD adjust, digit by digit, carrying/borrowing between nibbles.
    always_comb begin
        lo_add     = {2'b00, a_q[3:0]} + {2'b00, b_q[3:0]} + {5'd0, c_in};
        lo_add_adj = (lo_add > 6'd9) ? lo_add + 6'd6 : lo_add;
        hi_add     = {2'b00, a_q[7:4]} + {2'b00, b_q[7:4]} + {5'd0, (lo_add_adj > 6'd15)};
        hi_add_adj = (hi_add > 6'd9) ? hi_add + 6'd6 : hi_add;
        lo_sub     = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, ~c_in};
        lo_sub_adj = lo_sub[4] ? lo_sub[3:0] - 4'd6 : lo_sub[3:0];
        hi_sub     = {1'b0, a_q[7:4]} - {1'b0, b_q[7:4]} - {4'd0, lo_sub[4]};
        hi_sub_adj = hi_sub[4] ? hi_sub[3:0] - 4'd6 : hi_sub[3:0];
        if (op_q == OP_SBC) begin
            dec_r = {hi_sub_adj, lo_sub_adj};
            dec_c = ~hi_sub[4];
        end else begin
            dec_r = {hi_add_adj[3:0], lo_add_adj[3:0]};
            dec_c = (hi_add_adj > 6'd15);
        end
    end

    always_comb begin
        done_d   = 1'b0;
        stb_d    = '0;
        result_d = result_q;
        status_d = status_q;
        if ((state_q == CALC && !is_dec) || state_q == ADJ) begin
            done_d = 1'b1;
            if (op_q >= OP_NOP) begin
                status_d = p_q;
            end else begin
                if (state_q == ADJ) begin
                    result_d = dec_r;
                    status_d = {dec_r[7], bin_v, p_q[5:2], (dec_r == 8'd0), dec_c};
                end else begin
                    result_d = bin_r;
                    status_d = {bin_n, bin_v, p_q[5:2], bin_z, bin_c};
                end
                stb_d[0] = 1'b1;
                if (writes_reg) begin
                    case (dest_q)
                        3'd1:    stb_d[4] = 1'b1;
                        3'd2:    stb_d[3] = 1'b1;
                        3'd3:    stb_d[2] = 1'b1;
                        3'd4:    stb_d[1] = 1'b1;
                        default: stb_d    = 5'b00001;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            dest_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            stb_q    <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            dest_q   <= dest_d;
            done_q   <= done_d;
            result_q <= result_d;
            status_q <= status_d;
            stb_q    <= stb_d;
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = done_q;
    assign bus.result            = result_q;
    assign bus.status_out        = status_q;
    assign bus.accumulator_con   = stb_q[4];
    assign bus.x_con             = stb_q[3];
    assign bus.y_con             = stb_q[2];
    assign bus.stack_pointer_con = stb_q[1];
    assign bus.status_con        = stb_q[0];
endmodule
